// File: rtl/latency_monitor_pkg.sv
// Shared types and helpers for the multi-channel input-latency monitor.
//   disp_sel_t   : statistic routed to the HEX displays
//   chan_state_t : per-channel measurement state
//   ch_width()   : width of a channel-select field (never below 1 bit)
package latency_monitor_pkg;

  typedef enum logic [1:0] {
    LAST    = 2'd0,
    MIN     = 2'd1,
    MAX     = 2'd2,
    SAMPLES = 2'd3
  } disp_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } chan_state_t;

  localparam int unsigned DISP_W     = 24;
  localparam int unsigned NUM_DIGITS = 6;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/latency_monitor_if.sv
// Bus between the game-side logic and the latency monitor.
//   state_update : per-channel one-cycle pulse, game state changed
//   V_SYNC       : vertical sync from the (S)VGA timing module
//   clear_stats  : synchronous clear of min/max/samples/overflow
//   disp_ch      : channel shown on the displays
//   disp_sel     : statistic shown on the displays
//   overflow     : sticky per-channel counter saturation
//   busy         : per-channel measurement in progress
//   HEX0..HEX5   : seven-segment outputs, HEX0 least significant
// master drives the stimulus side, slave is the monitor.
interface latency_monitor_if
  import latency_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] state_update;
  logic              V_SYNC;
  logic              clear_stats;
  logic [CH_W-1:0]   disp_ch;
  disp_sel_t         disp_sel;
  logic [NUM_CH-1:0] overflow;
  logic [NUM_CH-1:0] busy;
  logic [6:0]        HEX0;
  logic [6:0]        HEX1;
  logic [6:0]        HEX2;
  logic [6:0]        HEX3;
  logic [6:0]        HEX4;
  logic [6:0]        HEX5;

  modport master (
    output state_update, V_SYNC, clear_stats, disp_ch, disp_sel,
    input  overflow, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  state_update, V_SYNC, clear_stats, disp_ch, disp_sel,
    output overflow, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

endinterface

// File: rtl/SevenSegmentDigit.sv
// Hex nibble to active-low seven-segment decoder (segment order gfedcba).
//   value    : nibble to show
//   blank    : force all segments off
//   segments : active-low segment drives
module SevenSegmentDigit (
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h7F;
    if (!blank) begin
      unique case (value)
        4'h0: segments = 7'h40;
        4'h1: segments = 7'h79;
        4'h2: segments = 7'h24;
        4'h3: segments = 7'h30;
        4'h4: segments = 7'h19;
        4'h5: segments = 7'h12;
        4'h6: segments = 7'h02;
        4'h7: segments = 7'h78;
        4'h8: segments = 7'h00;
        4'h9: segments = 7'h10;
        4'hA: segments = 7'h08;
        4'hB: segments = 7'h03;
        4'hC: segments = 7'h46;
        4'hD: segments = 7'h21;
        4'hE: segments = 7'h06;
        4'hF: segments = 7'h0E;
      endcase
    end
  end

endmodule

// File: rtl/latency_channel.sv
// One latency-measurement channel: IDLE/COUNT FSM, saturating cycle counter,
// last/min/max/sample statistics and a sticky overflow flag.
//   clk, rst     : clock, asynchronous active-high reset
//   state_update : start (or restart) a measurement
//   vs_edge      : shared qualifying sync edge
//   clear_stats  : clear min/max/samples/overflow
//   busy         : measurement in progress
//   overflow     : counter reached saturation since last clear
//   last, min_val, max_val, samples : statistics
module latency_channel
  import latency_monitor_pkg::*;
#(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned COMPUTE_DELAY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                state_update,
  input  logic                vs_edge,
  input  logic                clear_stats,
  output logic                busy,
  output logic                overflow,
  output logic [CNT_W-1:0]    last,
  output logic [CNT_W-1:0]    min_val,
  output logic [CNT_W-1:0]    max_val,
  output logic [SAMPLE_W-1:0] samples
);

  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = '1;

  chan_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    min_q, min_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic [SAMPLE_W-1:0] samples_q, samples_d;
  logic                ovf_q, ovf_d;
  logic                complete;

  // Edges arriving before the game logic could have produced a frame are ignored.
  assign complete = (state_q == COUNT) && vs_edge && (32'(cnt_q) >= COMPUTE_DELAY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    min_d     = min_q;
    max_d     = max_q;
    samples_d = samples_q;
    ovf_d     = ovf_q;

    if (state_update) begin
      // A fresh update restarts timing; a coinciding completion is discarded.
      state_d = COUNT;
      cnt_d   = '0;
    end else if (state_q == COUNT) begin
      if (complete) begin
        state_d = IDLE;
        last_d  = cnt_q;
        if (cnt_q < min_q) min_d = cnt_q;
        if (cnt_q > max_q) max_d = cnt_q;
        if (samples_q != SAMPLE_MAX) samples_d = samples_q + SAMPLE_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_MAX) ovf_d = 1'b1;
      end
    end

    if (clear_stats) begin
      min_d     = '1;
      max_d     = '0;
      samples_d = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      min_q     <= '1;
      max_q     <= '0;
      samples_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      min_q     <= min_d;
      max_q     <= max_d;
      samples_q <= samples_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = (state_q == COUNT);
  assign overflow = ovf_q;
  assign last     = last_q;
  assign min_val  = min_q;
  assign max_val  = max_q;
  assign samples  = samples_q;

endmodule

// File: rtl/latency_monitor.sv
// Multi-channel input-latency monitor. Measures cycles from each channel's
// state update to the next qualifying vertical-sync edge and shows a selected
// statistic on six seven-segment digits.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : latency_monitor_if slave (inputs, busy/overflow, HEX0..HEX5)
module latency_monitor
  import latency_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH           = 2,
  parameter int unsigned CNT_W            = 24,
  parameter int unsigned SAMPLE_W         = 16,
  parameter int unsigned COMPUTE_DELAY    = 4,
  parameter int unsigned VSYNC_ACTIVE_LOW = 1,
  parameter int unsigned BLANK_ZEROS      = 1
) (
  input  logic            clk,
  input  logic            rst,
  latency_monitor_if.slave bus
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic                sync_act;
  logic                sync_prev_q;
  logic                vs_edge;
  logic [NUM_CH-1:0]   busy_vec;
  logic [NUM_CH-1:0]   ovf_vec;
  logic [CNT_W-1:0]    last_arr [NUM_CH];
  logic [CNT_W-1:0]    min_arr  [NUM_CH];
  logic [CNT_W-1:0]    max_arr  [NUM_CH];
  logic [SAMPLE_W-1:0] samp_arr [NUM_CH];
  logic [DISP_W-1:0]   disp_d, disp_q;
  logic [NUM_DIGITS-1:0] blank;
  logic [6:0]          hex [NUM_DIGITS];

  // Normalise polarity so sync_act is high during the sync pulse.
  assign sync_act = bus.V_SYNC ^ (VSYNC_ACTIVE_LOW != 0);
  assign vs_edge  = sync_act & ~sync_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_prev_q <= 1'b0;
    end else begin
      sync_prev_q <= sync_act;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    latency_channel #(
      .CNT_W        (CNT_W),
      .SAMPLE_W     (SAMPLE_W),
      .COMPUTE_DELAY(COMPUTE_DELAY)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .state_update(bus.state_update[g]),
      .vs_edge     (vs_edge),
      .clear_stats (bus.clear_stats),
      .busy        (busy_vec[g]),
      .overflow    (ovf_vec[g]),
      .last        (last_arr[g]),
      .min_val     (min_arr[g]),
      .max_val     (max_arr[g]),
      .samples     (samp_arr[g])
    );
  end

  assign bus.busy     = busy_vec;
  assign bus.overflow = ovf_vec;

  // An unmatched disp_ch (beyond NUM_CH) leaves the value at zero.
  always_comb begin
    disp_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.disp_ch == CH_W'(i)) begin
        unique case (bus.disp_sel)
          LAST:    disp_d = DISP_W'(last_arr[i]);
          MIN:     disp_d = (samp_arr[i] == '0) ? '0 : DISP_W'(min_arr[i]);
          MAX:     disp_d = DISP_W'(max_arr[i]);
          SAMPLES: disp_d = DISP_W'(samp_arr[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q <= '0;
    end else begin
      disp_q <= disp_d;
    end
  end

  for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_digit
    if (n == 0) begin : g_lsd
      assign blank[n] = 1'b0;
    end else begin : g_msd
      // Leading zero: this nibble and every more significant one are zero.
      assign blank[n] = (BLANK_ZEROS != 0) && (disp_q[DISP_W-1:4*n] == '0);
    end

    SevenSegmentDigit u_digit (
      .value   (disp_q[4*n +: 4]),
      .blank   (blank[n]),
      .segments(hex[n])
    );
  end

  assign bus.HEX0 = hex[0];
  assign bus.HEX1 = hex[1];
  assign bus.HEX2 = hex[2];
  assign bus.HEX3 = hex[3];
  assign bus.HEX4 = hex[4];
  assign bus.HEX5 = hex[5];

endmodule

// File: tb/tb_latency_monitor.sv
module tb_latency_monitor;
  import latency_monitor_pkg::*;

  localparam int unsigned A_CH   = 3;
  localparam int unsigned A_CD   = 4;
  localparam int unsigned A_CMAX = 32'h00FF_FFFF;
  localparam int unsigned A_SMAX = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  latency_monitor_if #(.NUM_CH(A_CH)) a_if ();
  latency_monitor_if #(.NUM_CH(1))    b_if ();

  // Main instance: defaults with an extra, non-power-of-two channel count.
  latency_monitor #(
    .NUM_CH(A_CH), .CNT_W(24), .SAMPLE_W(16), .COMPUTE_DELAY(A_CD),
    .VSYNC_ACTIVE_LOW(1), .BLANK_ZEROS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );

  // Small instance: narrow counter, active-high sync, no blanking.
  latency_monitor #(
    .NUM_CH(1), .CNT_W(4), .SAMPLE_W(4), .COMPUTE_DELAY(4),
    .VSYNC_ACTIVE_LOW(0), .BLANK_ZEROS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- expected display encoding ----------------
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex(input logic [23:0] v, input bit blank_zeros);
    logic [41:0] r;
    logic [3:0]  nib;
    bit          lead;
    lead = 1'b1;
    r    = '0;
    for (int n = 5; n >= 0; n--) begin
      nib = v[4*n +: 4];
      if (nib != 4'h0) lead = 1'b0;
      r[7*n +: 7] = (blank_zeros && lead && n > 0) ? 7'h7F : seg7(nib);
    end
    return r;
  endfunction

  function automatic logic [41:0] hex_a();
    return {a_if.HEX5, a_if.HEX4, a_if.HEX3, a_if.HEX2, a_if.HEX1, a_if.HEX0};
  endfunction

  function automatic logic [41:0] hex_b();
    return {b_if.HEX5, b_if.HEX4, b_if.HEX3, b_if.HEX2, b_if.HEX1, b_if.HEX0};
  endfunction

  // ---------------- reference model for dut_a ----------------
  // Each channel remembers the cycle stamp of its last update; the latency of
  // a sync edge is the cycle distance minus one, capped at the counter range.
  logic [A_CH-1:0] m_act;
  logic [A_CH-1:0] m_ovf;
  int unsigned     m_start [A_CH];
  int unsigned     m_last  [A_CH];
  int unsigned     m_min   [A_CH];
  int unsigned     m_max   [A_CH];
  int unsigned     m_samp  [A_CH];
  logic [23:0]     m_disp;
  logic            m_sprev;
  int unsigned     m_cyc;
  logic            a_edge;

  assign a_edge = ~a_if.V_SYNC & ~m_sprev;

  function automatic int unsigned m_cnt(input int i);
    int unsigned k;
    k = m_cyc - m_start[i];
    return (k - 1 > A_CMAX) ? A_CMAX : k - 1;
  endfunction

  function automatic logic [23:0] model_sel(input logic [1:0] ch, input disp_sel_t s);
    if (ch >= A_CH) return 24'h0;
    case (s)
      LAST:    return 24'(m_last[ch]);
      MIN:     return (m_samp[ch] == 0) ? 24'h0 : 24'(m_min[ch]);
      MAX:     return 24'(m_max[ch]);
      default: return 24'(m_samp[ch]);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < A_CH; i++) begin
        m_start[i] <= 0;
        m_last[i]  <= 0;
        m_min[i]   <= A_CMAX;
        m_max[i]   <= 0;
        m_samp[i]  <= 0;
      end
      m_act   <= '0;
      m_ovf   <= '0;
      m_disp  <= '0;
      m_sprev <= 1'b0;
      m_cyc   <= 0;
    end else begin
      m_cyc   <= m_cyc + 1;
      m_sprev <= ~a_if.V_SYNC;
      m_disp  <= model_sel(a_if.disp_ch, a_if.disp_sel);
      for (int i = 0; i < A_CH; i++) begin
        if (a_if.state_update[i]) begin
          m_act[i]   <= 1'b1;
          m_start[i] <= m_cyc;
        end else if (m_act[i]) begin
          if (a_edge && m_cnt(i) >= A_CD) begin
            m_act[i]  <= 1'b0;
            m_last[i] <= m_cnt(i);
            if (m_cnt(i) < m_min[i]) m_min[i] <= m_cnt(i);
            if (m_cnt(i) > m_max[i]) m_max[i] <= m_cnt(i);
            if (m_samp[i] < A_SMAX) m_samp[i] <= m_samp[i] + 1;
          end else if (m_cnt(i) == A_CMAX - 1) begin
            m_ovf[i] <= 1'b1;
          end
        end
        if (a_if.clear_stats) begin
          m_min[i]  <= A_CMAX;
          m_max[i]  <= 0;
          m_samp[i] <= 0;
          m_ovf[i]  <= 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    a_if.state_update = '0; a_if.V_SYNC = 1'b1; a_if.clear_stats = 1'b0;
    a_if.disp_ch = '0; a_if.disp_sel = LAST;
    b_if.state_update = '0; b_if.V_SYNC = 1'b0; b_if.clear_stats = 1'b0;
    b_if.disp_ch = '0; b_if.disp_sel = LAST;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_if.busy !== 3'b000 || a_if.overflow !== 3'b000) begin
      failures++;
      $display("FAIL reset_a_flags busy=%b ovf=%b want 000/000", a_if.busy, a_if.overflow);
    end
    checks++;
    if (hex_a() !== exp_hex(24'h0, 1'b1)) begin
      failures++;
      $display("FAIL reset_a_hex got=%h want=%h", hex_a(), exp_hex(24'h0, 1'b1));
    end
    checks++;
    if (hex_b() !== exp_hex(24'h0, 1'b0) || b_if.busy !== 1'b0 || b_if.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_b got hex=%h busy=%b ovf=%b want hex=%h 0/0",
               hex_b(), b_if.busy, b_if.overflow, exp_hex(24'h0, 1'b0));
    end
    go(2);
    rst = 1'b0;
    go(2);
  endtask

  task automatic test_basic();
    go(1);
    a_if.disp_ch = 2'd0; a_if.disp_sel = LAST; a_if.state_update = 3'b001;
    go(1);
    a_if.state_update = '0;
    go(99);
    a_if.V_SYNC = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_at_edge got=%b want=1", a_if.busy[0]);
    end
    go(1);
    a_if.V_SYNC = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_after got=%b want=0", a_if.busy[0]);
    end
    go(1);
    @(negedge clk);
    checks++;
    if (hex_a() !== exp_hex(24'h63, 1'b1)) begin
      failures++;
      $display("FAIL basic_last got=%h want=%h", hex_a(), exp_hex(24'h63, 1'b1));
    end
    a_if.disp_sel = SAMPLES;
    go(1);
    @(negedge clk);
    checks++;
    if (hex_a() !== exp_hex(24'h1, 1'b1)) begin
      failures++;
      $display("FAIL basic_samples got=%h want=%h", hex_a(), exp_hex(24'h1, 1'b1));
    end
    go(2);
  endtask

  task automatic test_gating();
    a_if.disp_ch = 2'd1; a_if.disp_sel = LAST; a_if.state_update = 3'b010;
    go(1);
    a_if.state_update = '0;
    go(3);
    a_if.V_SYNC = 1'b0;   // edge at cnt=3, below the compute delay
    go(1);
    a_if.V_SYNC = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL gating_busy_early got=%b want=1", a_if.busy[1]);
    end
    go(55);
    a_if.V_SYNC = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL gating_busy_at_edge got=%b want=1", a_if.busy[1]);
    end
    go(1);
    a_if.V_SYNC = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL gating_busy_after got=%b want=0", a_if.busy[1]);
    end
    go(1);
    @(negedge clk);
    checks++;
    if (hex_a() !== exp_hex(24'h3B, 1'b1)) begin
      failures++;
      $display("FAIL gating_last got=%h want=%h", hex_a(), exp_hex(24'h3B, 1'b1));
    end
    a_if.disp_ch = 2'd3;  // no such channel
    go(1);
    @(negedge clk);
    checks++;
    if (hex_a() !== exp_hex(24'h0, 1'b1)) begin
      failures++;
      $display("FAIL range_ch3 got=%h want=%h", hex_a(), exp_hex(24'h0, 1'b1));
    end
    go(2);
  endtask

  task automatic test_restart();
    a_if.clear_stats = 1'b1;
    go(1);
    a_if.clear_stats = 1'b0;
    a_if.disp_ch = 2'd0; a_if.disp_sel = SAMPLES; a_if.state_update = 3'b001;
    go(1);
    a_if.state_update = '0;
    go(49);
    a_if.state_update = 3'b001;  // restart coincides with an edge
    a_if.V_SYNC = 1'b0;
    go(1);
    a_if.state_update = '0;
    a_if.V_SYNC = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL restart_busy got=%b want=1", a_if.busy[0]);
    end
    go(1);
    @(negedge clk);
    checks++;
    if (hex_a() !== exp_hex(24'h0, 1'b1)) begin
      failures++;
      $display("FAIL restart_discarded got=%h want=%h", hex_a(), exp_hex(24'h0, 1'b1));
    end
    go(98);
    a_if.V_SYNC = 1'b0;
    go(1);
    a_if.V_SYNC = 1'b1;
    go(1);
    @(negedge clk);
    checks++;
    if (hex_a() !== exp_hex(24'h1, 1'b1)) begin
      failures++;
      $display("FAIL restart_samples got=%h want=%h", hex_a(), exp_hex(24'h1, 1'b1));
    end
    a_if.disp_sel = LAST;
    go(1);
    @(negedge clk);
    checks++;
    if (hex_a() !== exp_hex(24'h63, 1'b1)) begin
      failures++;
      $display("FAIL restart_last got=%h want=%h", hex_a(), exp_hex(24'h63, 1'b1));
    end
    go(2);
  endtask

  task automatic test_minmax();
    int unsigned lats [3];
    disp_sel_t   sels [4];
    logic [23:0] want [4];
    lats = '{20, 7, 45};
    sels = '{MIN, MAX, SAMPLES, LAST};
    a_if.disp_ch = 2'd0;
    a_if.clear_stats = 1'b1;
    go(1);
    a_if.clear_stats = 1'b0;
    for (int m = 0; m < 3; m++) begin
      a_if.state_update = 3'b001;
      go(1);
      a_if.state_update = '0;
      go(lats[m]);
      a_if.V_SYNC = 1'b0;
      go(1);
      a_if.V_SYNC = 1'b1;
      go(2);
    end
    want = '{24'h7, 24'h2D, 24'h3, 24'h2D};
    for (int s = 0; s < 4; s++) begin
      a_if.disp_sel = sels[s];
      go(1);
      @(negedge clk);
      checks++;
      if (hex_a() !== exp_hex(want[s], 1'b1)) begin
        failures++;
        $display("FAIL minmax_sel%0d got=%h want=%h", s, hex_a(), exp_hex(want[s], 1'b1));
      end
    end
    go(1);
    a_if.clear_stats = 1'b1;
    go(1);
    a_if.clear_stats = 1'b0;
    want = '{24'h0, 24'h0, 24'h0, 24'h2D};
    for (int s = 0; s < 4; s++) begin
      a_if.disp_sel = sels[s];
      go(1);
      @(negedge clk);
      checks++;
      if (hex_a() !== exp_hex(want[s], 1'b1)) begin
        failures++;
        $display("FAIL cleared_sel%0d got=%h want=%h", s, hex_a(), exp_hex(want[s], 1'b1));
      end
    end
    go(2);
  endtask

  task automatic test_saturation();
    b_if.disp_ch = 1'b0; b_if.disp_sel = LAST; b_if.state_update = 1'b1;
    go(1);
    b_if.state_update = 1'b0;
    go(14);
    @(negedge clk);
    checks++;
    if (b_if.overflow !== 1'b0) begin
      failures++;
      $display("FAIL sat_before got=%b want=0", b_if.overflow);
    end
    go(1);
    @(negedge clk);
    checks++;
    if (b_if.overflow !== 1'b1 || b_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL sat_reached ovf=%b busy=%b want 1/1", b_if.overflow, b_if.busy);
    end
    go(24);
    b_if.V_SYNC = 1'b1;  // active-high sync pulse
    go(1);
    b_if.V_SYNC = 1'b0;
    go(1);
    @(negedge clk);
    checks++;
    if (hex_b() !== exp_hex(24'hF, 1'b0) || b_if.overflow !== 1'b1) begin
      failures++;
      $display("FAIL sat_last got hex=%h ovf=%b want hex=%h ovf=1",
               hex_b(), b_if.overflow, exp_hex(24'hF, 1'b0));
    end
    b_if.clear_stats = 1'b1;
    go(1);
    b_if.clear_stats = 1'b0;
    @(negedge clk);
    checks++;
    if (b_if.overflow !== 1'b0 || hex_b() !== exp_hex(24'hF, 1'b0)) begin
      failures++;
      $display("FAIL sat_cleared got ovf=%b hex=%h want ovf=0 hex=%h",
               b_if.overflow, hex_b(), exp_hex(24'hF, 1'b0));
    end
    go(2);
  endtask

  task automatic test_reset_mid();
    a_if.disp_ch = 2'd0; a_if.disp_sel = LAST;
    a_if.state_update = 3'b001; b_if.state_update = 1'b1;
    go(1);
    a_if.state_update = '0; b_if.state_update = 1'b0;
    go(20);
    checks++;
    if (a_if.busy[0] !== 1'b1 || b_if.overflow !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre a_busy=%b b_ovf=%b want 1/1", a_if.busy[0], b_if.overflow);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_if.busy !== 3'b000 || b_if.busy !== 1'b0 || b_if.overflow !== 1'b0) begin
      failures++;
      $display("FAIL midrst_flags a_busy=%b b_busy=%b b_ovf=%b want 000/0/0",
               a_if.busy, b_if.busy, b_if.overflow);
    end
    checks++;
    if (hex_a() !== exp_hex(24'h0, 1'b1) || hex_b() !== exp_hex(24'h0, 1'b0)) begin
      failures++;
      $display("FAIL midrst_hex a=%h b=%h want a=%h b=%h",
               hex_a(), hex_b(), exp_hex(24'h0, 1'b1), exp_hex(24'h0, 1'b0));
    end
    go(1);
    rst = 1'b0;
    go(2);
    a_if.V_SYNC = 1'b0;
    go(1);
    a_if.V_SYNC = 1'b1;
    go(1);
    @(negedge clk);
    checks++;
    if (a_if.busy !== 3'b000 || hex_a() !== exp_hex(24'h0, 1'b1)) begin
      failures++;
      $display("FAIL midrst_edge busy=%b hex=%h want 000 hex=%h",
               a_if.busy, hex_a(), exp_hex(24'h0, 1'b1));
    end
    go(2);
  endtask

  task automatic test_random();
    logic [A_CH-1:0] u;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < A_CH; i++) u[i] = ($urandom_range(0, 39) == 0);
      a_if.state_update = u;
      a_if.V_SYNC       = ($urandom_range(0, 11) != 0);
      a_if.clear_stats  = ($urandom_range(0, 299) == 0);
      a_if.disp_ch      = 2'($urandom_range(0, 3));
      a_if.disp_sel     = disp_sel_t'(2'($urandom_range(0, 3)));
      @(negedge clk);
      checks++;
      if (a_if.busy !== m_act || a_if.overflow !== m_ovf) begin
        failures++;
        $display("FAIL rand_flags c=%0d busy=%b ovf=%b want %b/%b",
                 c, a_if.busy, a_if.overflow, m_act, m_ovf);
      end
      checks++;
      if (hex_a() !== exp_hex(m_disp, 1'b1)) begin
        failures++;
        $display("FAIL rand_hex c=%0d got=%h want=%h (value %h)",
                 c, hex_a(), exp_hex(m_disp, 1'b1), m_disp);
      end
      go(1);
    end
    a_if.state_update = '0;
    a_if.V_SYNC = 1'b1;
    a_if.clear_stats = 1'b0;
    go(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gating();
    test_restart();
    test_minmax();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
